// File: rtl/motor_guard_pkg.sv
// Shared encodings for the motor reversal guard: FSM state codes and the
// decoded per-cycle direction command.
package motor_guard_pkg;

  localparam logic [2:0] ST_COAST = 3'd0;
  localparam logic [2:0] ST_FWD   = 3'd1;
  localparam logic [2:0] ST_BWD   = 3'd2;
  localparam logic [2:0] ST_DEAD  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  typedef enum logic [1:0] {
    CMD_STOP    = 2'd0,
    CMD_FWD     = 2'd1,
    CMD_BWD     = 2'd2,
    CMD_ILLEGAL = 2'd3
  } cmd_t;

  // Pause is a stop request; otherwise the raw level pair selects the command.
  function automatic cmd_t decode_cmd(input logic fwd, input logic bwd, input logic pause);
    cmd_t cmd;
    if (pause) begin
      cmd = CMD_STOP;
    end else begin
      case ({fwd, bwd})
        2'b10:   cmd = CMD_FWD;
        2'b01:   cmd = CMD_BWD;
        2'b11:   cmd = CMD_ILLEGAL;
        default: cmd = CMD_STOP;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/guard_counter.sv
// Saturating up-counter with synchronous clear and enable. tc flags the last
// count before saturation (TERM-1), so a block that acts on tc together with
// its own qualifying condition sees exactly TERM qualifying cycles.
module guard_counter #(
  parameter int CNT_W = 20,
  parameter int TERM  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TERM - 1);
  localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(TERM);

  logic [CNT_W-1:0] count;

  // Count qualifying cycles; clear wins over enable, hold once saturated.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != SAT_VAL)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/motor_reversal_guard.sv
// Direction safety stage for one H-bridge channel. Inserts a coast dead-time
// on every exit from a drive direction, never drives both directions, honours
// the drive-train pause and latches a fault on persistent shoot-through
// requests. Outputs are decoded straight from the state register.
module motor_reversal_guard
  import motor_guard_pkg::*;
#(
  parameter int DEAD_CYCLES  = 500000,
  parameter int FAULT_CYCLES = 1000,
  parameter int CNT_W = $clog2(((DEAD_CYCLES > FAULT_CYCLES) ? DEAD_CYCLES : FAULT_CYCLES) + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic fwd_in,
  input  logic bwd_in,
  input  logic pause_in,
  output logic fwd_out,
  output logic bwd_out,
  output logic dead_active,
  output logic fault
);

  logic [2:0] state;
  logic [2:0] next_state;
  cmd_t       cmd;
  logic       illegal_raw;
  logic       dead_tc;
  logic       illegal_tc;

  assign cmd         = decode_cmd(fwd_in, bwd_in, pause_in);
  // The shoot-through check looks at the raw levels, so pause does not hide it.
  assign illegal_raw = fwd_in & bwd_in;

  // Dead-time counter: held at zero outside DEAD, so DEAD always starts at 0.
  guard_counter #(
    .CNT_W (CNT_W),
    .TERM  (DEAD_CYCLES)
  ) u_dead_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_DEAD),
    .en  (state == ST_DEAD),
    .tc  (dead_tc)
  );

  // Shoot-through persistence: consecutive cycles with both levels high.
  guard_counter #(
    .CNT_W (CNT_W),
    .TERM  (FAULT_CYCLES)
  ) u_illegal_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!illegal_raw),
    .en  (illegal_raw),
    .tc  (illegal_tc)
  );

  // Next-state logic; a fault trip overrides every other transition.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_COAST: begin
        if (cmd == CMD_FWD)      next_state = ST_FWD;
        else if (cmd == CMD_BWD) next_state = ST_BWD;
      end
      ST_FWD: begin
        if (cmd != CMD_FWD) next_state = ST_DEAD;
      end
      ST_BWD: begin
        if (cmd != CMD_BWD) next_state = ST_DEAD;
      end
      ST_DEAD: begin
        if (dead_tc) begin
          if (cmd == CMD_FWD)      next_state = ST_FWD;
          else if (cmd == CMD_BWD) next_state = ST_BWD;
          else                     next_state = ST_COAST;
        end
      end
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_COAST;
    endcase
    if (illegal_raw && illegal_tc) begin
      next_state = ST_FAULT;
    end
  end

  // State register; reset drops straight to COAST with no dead time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_COAST;
    end else begin
      state <= next_state;
    end
  end

  assign fwd_out     = (state == ST_FWD);
  assign bwd_out     = (state == ST_BWD);
  assign dead_active = (state == ST_DEAD);
  assign fault       = (state == ST_FAULT);

endmodule

// File: tb/tb_motor_reversal_guard.sv
// Scoreboard bench for motor_reversal_guard with DEAD_CYCLES=4, FAULT_CYCLES=3.
// A behavioural model pushes the expected outputs for each driven cycle; they
// are popped and compared one time unit after the following rising edge.
module tb_motor_reversal_guard;

  localparam int D_CYC = 4;
  localparam int F_CYC = 3;

  localparam int M_COAST = 0;
  localparam int M_FWD   = 1;
  localparam int M_BWD   = 2;
  localparam int M_DEAD  = 3;
  localparam int M_FAULT = 4;

  typedef struct packed {
    logic fwd;
    logic bwd;
    logic dead;
    logic flt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fwd_in = 1'b0;
  logic bwd_in = 1'b0;
  logic pause_in = 1'b0;
  logic fwd_out;
  logic bwd_out;
  logic dead_active;
  logic fault;

  int n_cmp = 0;
  int n_err = 0;

  int m_state   = M_COAST;
  int dead_left = 0;
  int ill_run   = 0;

  exp_t sb_q[$];

  motor_reversal_guard #(
    .DEAD_CYCLES  (D_CYC),
    .FAULT_CYCLES (F_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fwd_in      (fwd_in),
    .bwd_in      (bwd_in),
    .pause_in    (pause_in),
    .fwd_out     (fwd_out),
    .bwd_out     (bwd_out),
    .dead_active (dead_active),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("FAIL %s @%0t: got %b, want %b", tag, $time, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_state   = M_COAST;
    dead_left = 0;
    ill_run   = 0;
  endtask

  // Advance the reference model by one clock edge for the given inputs.
  task automatic model_step(input logic f, input logic b, input logic p);
    int dir;
    if (f && b) ill_run++;
    else        ill_run = 0;
    if (p || (f == b)) dir = 0;
    else if (f)        dir = 1;
    else               dir = 2;
    if (ill_run >= F_CYC) begin
      m_state = M_FAULT;
    end else begin
      case (m_state)
        M_COAST: begin
          if (dir == 1)      m_state = M_FWD;
          else if (dir == 2) m_state = M_BWD;
        end
        M_FWD, M_BWD: begin
          if (dir != m_state) begin
            m_state   = M_DEAD;
            dead_left = D_CYC;
          end
        end
        M_DEAD: begin
          dead_left--;
          if (dead_left == 0) begin
            if (dir == 1)      m_state = M_FWD;
            else if (dir == 2) m_state = M_BWD;
            else               m_state = M_COAST;
          end
        end
        default: m_state = m_state;
      endcase
    end
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic drive(input logic f, input logic b, input logic p, input string tag);
    exp_t e;
    fwd_in   = f;
    bwd_in   = b;
    pause_in = p;
    model_step(f, b, p);
    e.fwd  = (m_state == M_FWD);
    e.bwd  = (m_state == M_BWD);
    e.dead = (m_state == M_DEAD);
    e.flt  = (m_state == M_FAULT);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".fwd"},   fwd_out,     e.fwd);
    check({tag, ".bwd"},   bwd_out,     e.bwd);
    check({tag, ".dead"},  dead_active, e.dead);
    check({tag, ".fault"}, fault,       e.flt);
    check({tag, ".excl"},  fwd_out & bwd_out, 1'b0);
  endtask

  task automatic drive_n(input int n, input logic f, input logic b, input logic p, input string tag);
    for (int i = 0; i < n; i++) drive(f, b, p, tag);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".fwd"},   fwd_out,     1'b0);
    check({tag, ".bwd"},   bwd_out,     1'b0);
    check({tag, ".dead"},  dead_active, 1'b0);
    check({tag, ".fault"}, fault,       1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fwd_in   = 1'b0;
    bwd_in   = 1'b0;
    pause_in = 1'b0;
    model_reset();
  endtask

  initial begin
    // Reset state.
    #1;
    check("rst.fwd",   fwd_out,     1'b0);
    check("rst.bwd",   bwd_out,     1'b0);
    check("rst.dead",  dead_active, 1'b0);
    check("rst.fault", fault,       1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Drive forward from COAST, then reverse through a full dead time.
    drive_n(3, 1'b1, 1'b0, 1'b0, "fwd");
    drive_n(6, 1'b0, 1'b1, 1'b0, "rev");

    // Back to forward, one stop cycle, then the same direction again.
    drive_n(6, 1'b1, 1'b0, 1'b0, "fwd2");
    drive(1'b0, 1'b0, 1'b0, "stop1");
    drive_n(5, 1'b1, 1'b0, 1'b0, "same");

    // Stop into COAST, then pause while requesting forward.
    drive_n(5, 1'b0, 1'b0, 1'b0, "coast");
    drive_n(6, 1'b1, 1'b0, 1'b1, "pause_coast");
    drive(1'b1, 1'b0, 1'b0, "unpause");
    drive_n(6, 1'b1, 1'b0, 1'b1, "pause_fwd");

    // Pause drops on the last DEAD cycle: the raw command picks FWD.
    drive_n(2, 1'b1, 1'b0, 1'b0, "fwd3");
    drive_n(3, 1'b1, 1'b0, 1'b1, "pause_dead");
    drive_n(2, 1'b1, 1'b0, 1'b0, "pause_drop");

    // Short shoot-through burst clears without a fault.
    drive_n(2, 1'b1, 1'b1, 1'b0, "ill2");
    drive_n(6, 1'b0, 1'b0, 1'b0, "ill_clr");
    drive_n(2, 1'b1, 1'b1, 1'b1, "ill2p");
    drive(1'b0, 1'b0, 1'b0, "ill_clr2");

    // Three consecutive illegal cycles from FWD trip the fault.
    drive_n(7, 1'b1, 1'b0, 1'b0, "fwd4");
    drive_n(3, 1'b1, 1'b1, 1'b0, "ill3");
    drive_n(2, 1'b1, 1'b0, 1'b0, "flt_hold");
    drive_n(2, 1'b0, 1'b1, 1'b0, "flt_hold2");
    pulse_reset("flt_rst");
    drive(1'b0, 1'b0, 1'b0, "post_flt");

    // Randomised stretch, mostly legal commands.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if (r == 4'd15) drive(1'b1, 1'b1, 1'b0, "rnd");
      else            drive(r[0], r[1] & ~r[0], r[2] & r[3], "rnd");
    end
    pulse_reset("rnd_rst");

    // Asynchronous reset in the middle of DEAD.
    drive_n(2, 1'b1, 1'b0, 1'b0, "fwd5");
    drive_n(2, 1'b0, 1'b0, 1'b0, "dead_mid");
    pulse_reset("async_rst");
    drive(1'b1, 1'b0, 1'b0, "post_rst");

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: got %0d left, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
